// File: rtl/hilo_unit_pkg.sv
// Shared HI/LO unit definitions: decoder control codes, widths and default latencies.
// The decoder, the hazard unit and hilo_unit all use these values.
package hilo_unit_pkg;

    localparam int unsigned DATA_W      = 32;
    localparam int unsigned HILO_CTRL_W = 5;
    localparam int unsigned CNT_W       = 4;

    localparam logic [HILO_CTRL_W-1:0] HILO_NONE  = 5'd0;
    localparam logic [HILO_CTRL_W-1:0] HILO_MULTU = 5'd1;
    localparam logic [HILO_CTRL_W-1:0] HILO_MULT  = 5'd2;
    localparam logic [HILO_CTRL_W-1:0] HILO_DIVU  = 5'd3;
    localparam logic [HILO_CTRL_W-1:0] HILO_DIV   = 5'd4;
    localparam logic [HILO_CTRL_W-1:0] HILO_MFHI  = 5'd5;
    localparam logic [HILO_CTRL_W-1:0] HILO_MFLO  = 5'd6;
    localparam logic [HILO_CTRL_W-1:0] HILO_MTHI  = 5'd7;
    localparam logic [HILO_CTRL_W-1:0] HILO_MTLO  = 5'd8;

    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;

    // True for the four codes that start a multi-cycle operation.
    function automatic logic is_muldiv(input logic [HILO_CTRL_W-1:0] code);
        return (code >= HILO_MULTU) && (code <= HILO_DIV);
    endfunction

endpackage

// File: rtl/hilo_arith.sv
// Combinational mult/div datapath producing the 64-bit {hi,lo} result.
// Signed division runs on magnitudes, so 0x80000000 / -1 yields a clean 0x80000000.
module hilo_arith
    import hilo_unit_pkg::*;
(
    input  logic [DATA_W-1:0]      a,
    input  logic [DATA_W-1:0]      b,
    input  logic [HILO_CTRL_W-1:0] code,
    output logic [2*DATA_W-1:0]    result,
    output logic                   div_by_zero
);

    logic [DATA_W-1:0]   w_a_mag;
    logic [DATA_W-1:0]   w_b_mag;
    logic [DATA_W-1:0]   w_b_safe;
    logic [DATA_W-1:0]   w_bmag_safe;
    logic [DATA_W-1:0]   w_q_mag;
    logic [DATA_W-1:0]   w_r_mag;
    logic [DATA_W-1:0]   w_q_s;
    logic [DATA_W-1:0]   w_r_s;
    logic [2*DATA_W-1:0] w_prod_u;
    logic [2*DATA_W-1:0] w_prod_s;

    assign w_a_mag     = a[DATA_W-1] ? (~a + DATA_W'(1)) : a;
    assign w_b_mag     = b[DATA_W-1] ? (~b + DATA_W'(1)) : b;
    assign w_b_safe    = (b == '0) ? DATA_W'(1) : b;
    assign w_bmag_safe = (b == '0) ? DATA_W'(1) : w_b_mag;

    assign w_q_mag = w_a_mag / w_bmag_safe;
    assign w_r_mag = w_a_mag % w_bmag_safe;
    assign w_q_s   = (a[DATA_W-1] ^ b[DATA_W-1]) ? (~w_q_mag + DATA_W'(1)) : w_q_mag;
    assign w_r_s   = a[DATA_W-1] ? (~w_r_mag + DATA_W'(1)) : w_r_mag;

    // Low 64 bits of the sign-extended product equal the signed product.
    assign w_prod_u = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
    assign w_prod_s = {{DATA_W{a[DATA_W-1]}}, a} * {{DATA_W{b[DATA_W-1]}}, b};

    always_comb begin
        result      = '0;
        div_by_zero = 1'b0;
        case (code)
            HILO_MULTU: result = w_prod_u;
            HILO_MULT:  result = w_prod_s;
            HILO_DIVU: begin
                result      = {a % w_b_safe, a / w_b_safe};
                div_by_zero = (b == '0);
            end
            HILO_DIV: begin
                result      = {w_r_s, w_q_s};
                div_by_zero = (b == '0);
            end
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/hilo_unit.sv
// E-stage HI/LO unit: owns HI/LO, runs mult/div with a fixed busy latency,
// and serves mfhi/mflo/mthi/mtlo.
module hilo_unit
    import hilo_unit_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [HILO_CTRL_W-1:0] hilo_ctrl,
    input  logic                   en,
    input  logic [DATA_W-1:0]      a,
    input  logic [DATA_W-1:0]      b,
    output logic                   start,
    output logic                   busy,
    output logic [DATA_W-1:0]      hi,
    output logic [DATA_W-1:0]      lo,
    output logic [DATA_W-1:0]      rd_data
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

    logic [0:0]          r_state, w_state_nxt;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
    logic [DATA_W-1:0]   r_hi, w_hi_nxt;
    logic [DATA_W-1:0]   r_lo, w_lo_nxt;
    logic [DATA_W-1:0]   r_pend_hi, w_pend_hi_nxt;
    logic [DATA_W-1:0]   r_pend_lo, w_pend_lo_nxt;
    logic                r_pend_valid, w_pend_valid_nxt;
    logic [2*DATA_W-1:0] w_result;
    logic                w_div_by_zero;
    logic                w_start;

    hilo_arith u_arith (
        .a           (a),
        .b           (b),
        .code        (hilo_ctrl),
        .result      (w_result),
        .div_by_zero (w_div_by_zero)
    );

    assign w_start = en & is_muldiv(hilo_ctrl) & (r_state == S_IDLE);
    assign start   = w_start;
    assign busy    = (r_state == S_RUN);
    assign hi      = r_hi;
    assign lo      = r_lo;

    always_comb begin
        rd_data = '0;
        case (hilo_ctrl)
            HILO_MFHI: rd_data = r_hi;
            HILO_MFLO: rd_data = r_lo;
            HILO_NONE: rd_data = '0;
            default:   rd_data = '0;
        endcase
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_hi_nxt         = r_hi;
        w_lo_nxt         = r_lo;
        w_pend_hi_nxt    = r_pend_hi;
        w_pend_lo_nxt    = r_pend_lo;
        w_pend_valid_nxt = r_pend_valid;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_pend_hi_nxt    = w_result[2*DATA_W-1:DATA_W];
                    w_pend_lo_nxt    = w_result[DATA_W-1:0];
                    w_pend_valid_nxt = ~w_div_by_zero;
                    w_cnt_nxt        = ((hilo_ctrl == HILO_MULTU) || (hilo_ctrl == HILO_MULT))
                                       ? MULT_LOAD : DIV_LOAD;
                    w_state_nxt      = S_RUN;
                end else if (en && (hilo_ctrl == HILO_MTHI)) begin
                    w_hi_nxt = a;
                end else if (en && (hilo_ctrl == HILO_MTLO)) begin
                    w_lo_nxt = a;
                end
            end
            S_RUN: begin
                // Commands arriving here are ignored; the stall logic should never send any.
                w_cnt_nxt = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = S_IDLE;
                    if (r_pend_valid) begin
                        w_hi_nxt = r_pend_hi;
                        w_lo_nxt = r_pend_lo;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_hi         <= '0;
            r_lo         <= '0;
            r_pend_hi    <= '0;
            r_pend_lo    <= '0;
            r_pend_valid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_hi         <= w_hi_nxt;
            r_lo         <= w_lo_nxt;
            r_pend_hi    <= w_pend_hi_nxt;
            r_pend_lo    <= w_pend_lo_nxt;
            r_pend_valid <= w_pend_valid_nxt;
        end
    end

endmodule

// File: tb/tb_hilo_unit.sv
// Self-checking bench for hilo_unit: vector table with a result scoreboard,
// random multu/divu against a local model, and hand-written busy/reset sequences.
module tb_hilo_unit;
    import hilo_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  hilo_ctrl;
    logic        en;
    logic [31:0] a, b;
    logic        start, busy;
    logic [31:0] hi, lo, rd_data;

    always #5 clk = ~clk;

    hilo_unit dut (
        .clk       (clk),
        .reset     (reset),
        .hilo_ctrl (hilo_ctrl),
        .en        (en),
        .a         (a),
        .b         (b),
        .start     (start),
        .busy      (busy),
        .hi        (hi),
        .lo        (lo),
        .rd_data   (rd_data)
    );

    typedef struct {
        logic [4:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          exp_cyc;
        logic        exp_start;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } sb_t;

    vec_t vecs[9];
    sb_t  sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Present one command for a single cycle and check start combinationally.
    task automatic issue(input logic [4:0] ctrl, input logic [31:0] va, input logic [31:0] vb,
                         input logic exp_start, input string name);
        @(negedge clk);
        hilo_ctrl = ctrl;
        en        = 1'b1;
        a         = va;
        b         = vb;
        #1 check({name, " start"}, 32'(start), 32'(exp_start));
        @(posedge clk);
        #1;
        hilo_ctrl = HILO_NONE;
        en        = 1'b0;
        a         = '0;
        b         = '0;
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (busy === 1'b1 && cyc < 64) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic complete(input string name);
        int  c;
        sb_t e;
        wait_idle(c);
        if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = sb_q.pop_front();
            check({name, " busy_cycles"}, 32'(c), 32'(e.cyc));
            check({name, " hi"}, hi, e.hi);
            check({name, " lo"}, lo, e.lo);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          c;
        logic [31:0] ra, rb;
        logic [63:0] p;

        vecs[0] = '{HILO_MULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5,  1'b1};
        vecs[1] = '{HILO_MULTU, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 5,  1'b1};
        vecs[2] = '{HILO_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10, 1'b1};
        vecs[3] = '{HILO_DIVU,  32'd7,        32'd0,        32'hFFFFFFFF, 32'hFFFFFFFD, 10, 1'b1};
        vecs[4] = '{HILO_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10, 1'b1};
        vecs[5] = '{HILO_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       10, 1'b1};
        vecs[6] = '{HILO_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 10, 1'b1};
        vecs[7] = '{HILO_MTHI,  32'h12345678, 32'd0,        32'h12345678, 32'hFFFFFFFD, 0,  1'b0};
        vecs[8] = '{HILO_MTLO,  32'hCAFEBABE, 32'd0,        32'h12345678, 32'hCAFEBABE, 0,  1'b0};

        reset     = 1'b1;
        en        = 1'b0;
        hilo_ctrl = HILO_NONE;
        a         = '0;
        b         = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check("reset busy", 32'(busy), 32'd0);
        check("reset hi", hi, 32'd0);
        check("reset lo", lo, 32'd0);
        check("reset start", 32'(start), 32'd0);
        check("reset rd_data", rd_data, 32'd0);

        for (int i = 0; i < 9; i++) begin
            sb_q.push_back('{vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].exp_cyc});
            issue(vecs[i].ctrl, vecs[i].a, vecs[i].b, vecs[i].exp_start, $sformatf("vec%0d", i));
            complete($sformatf("vec%0d", i));
        end

        // mflo/mfhi reads; en=0 blocks writes but not reads.
        @(negedge clk);
        hilo_ctrl = HILO_MFLO;
        en        = 1'b1;
        #1 check("mflo rd_data", rd_data, 32'hCAFEBABE);
        check("mflo start", 32'(start), 32'd0);
        hilo_ctrl = HILO_MFHI;
        en        = 1'b0;
        #1 check("mfhi en0 rd_data", rd_data, 32'h12345678);
        hilo_ctrl = HILO_MTLO;
        a         = 32'h11111111;
        @(posedge clk);
        #1 check("mtlo en0 lo", lo, 32'hCAFEBABE);
        hilo_ctrl = HILO_NONE;
        a         = '0;

        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            rb = $urandom;
            p  = {32'd0, ra} * {32'd0, rb};
            sb_q.push_back('{p[63:32], p[31:0], 5});
            issue(HILO_MULTU, ra, rb, 1'b1, $sformatf("rnd_multu%0d", i));
            complete($sformatf("rnd_multu%0d", i));
            rb = 32'($urandom_range(1, 1000));
            sb_q.push_back('{ra % rb, ra / rb, 10});
            issue(HILO_DIVU, ra, rb, 1'b1, $sformatf("rnd_divu%0d", i));
            complete($sformatf("rnd_divu%0d", i));
        end

        // Commands during a mult busy period are ignored.
        issue(HILO_MTHI, 32'h12345678, 32'd0, 1'b0, "pre_mthi");
        issue(HILO_MTLO, 32'hCAFEBABE, 32'd0, 1'b0, "pre_mtlo");
        issue(HILO_MULT, 32'd3, 32'd4, 1'b1, "busy_mult");
        check("busy_mult busy", 32'(busy), 32'd1);
        hilo_ctrl = HILO_MTHI;
        en        = 1'b1;
        a         = 32'h0000DEAD;
        #1 check("busy mthi start", 32'(start), 32'd0);
        @(posedge clk);
        #1;
        hilo_ctrl = HILO_MULT;
        a         = 32'd5;
        b         = 32'd5;
        #1 check("busy mult2 start", 32'(start), 32'd0);
        @(posedge clk);
        #1;
        hilo_ctrl = HILO_MFHI;
        #1 check("busy mfhi old hi", rd_data, 32'h12345678);
        @(posedge clk);
        #1;
        hilo_ctrl = HILO_NONE;
        en        = 1'b0;
        a         = '0;
        b         = '0;
        wait_idle(c);
        check("busy_mult busy_cycles", 32'(c + 3), 32'd5);
        check("busy_mult hi", hi, 32'd0);
        check("busy_mult lo", lo, 32'd12);

        // Reset in the third busy cycle of a div aborts it.
        issue(HILO_DIV, 32'd100, 32'd3, 1'b1, "rst_div");
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 check("rst_div busy before reset", 32'(busy), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        check("rst_div busy", 32'(busy), 32'd0);
        check("rst_div hi", hi, 32'd0);
        check("rst_div lo", lo, 32'd0);
        repeat (12) @(posedge clk);
        #1;
        check("rst_div late busy", 32'(busy), 32'd0);
        check("rst_div late hi", hi, 32'd0);
        check("rst_div late lo", lo, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hilo_unit.md
Name: hilo_unit

Overview:
- Execute-stage multiply/divide unit of the P6 five-stage MIPS pipeline.
- Consumes the 5-bit hiloCtrl code produced by the instruction decoder, together with the forwarded rs/rt operands.
- Owns the HI and LO architectural registers.
- Models multi-cycle mult/div latency with a busy handshake, which hazard logic uses to stall mult/div/mfhi/mflo/mthi/mtlo in D.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu.
- DIV_CYCLES, 10, busy cycles for div/divu.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- hilo_ctrl  in  5  decoder code: 0 none, 1 multu, 2 mult, 3 divu, 4 div, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, others none.
- en  in  1  E-stage instruction valid (0 for bubbles/flushed slots).
- a  in  32  rs operand (forwarded).
- b  in  32  rt operand (forwarded).
- start  out  1  combinational: en & code in 1..4 & !busy.
- busy  out  1  registered: an operation is in flight.
- hi  out  32  HI register.
- lo  out  32  LO register.
- rd_data  out  32  combinational: hi if code 5, lo if code 6, else 0.

Behaviour:
Reset:
- On reset (synchronous, active-high), sets hi=0, lo=0, busy=0, counter=0, and clears the pending result.
- Reset mid-operation aborts the operation; no result is committed.

States:
- IDLE (busy=0) and RUN (busy=1).
- A 4-bit down counter tracks remaining cycles.

IDLE:
- When start=1 at an edge, compute the result from a/b, latch it into pending_hi/pending_lo, and load the counter with MULT_CYCLES or DIV_CYCLES. Next state is RUN.
- When en=1 and code=7 (mthi) at an edge, hi<=a; lo is unchanged.
- When en=1 and code=8 (mtlo) at an edge, lo<=a.

RUN:
- Each edge decrements the counter.
- At the edge where the counter goes 1->0, hi<=pending_hi, lo<=pending_lo, busy<=0, and the next state is IDLE.
- busy is therefore high for exactly N cycles following the start cycle.
- The first cycle with busy=0 shows the new hi/lo values.

Arithmetic:
- multu: {hi,lo} = zero-extended 64-bit product.
- mult: signed 64-bit product.
- divu: lo = a/b, hi = a%b, unsigned.
- div: signed; quotient truncated toward zero, remainder takes the sign of the dividend.
- 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- Division by zero (b=0) still runs the full DIV_CYCLES busy period, but hi/lo keep their prior values.

Boundary conditions:
- Any hilo_ctrl command while busy=1 is ignored: start stays 0 and no mthi/mtlo write occurs. The stall logic is required to prevent this; the unit is defensive only.
- mfhi/mflo while busy returns the old hi/lo; this is legal only under stall, and the unit does not block it.
- en=0 suppresses start and mthi/mtlo writes; rd_data still follows the code.
- Reads and writes in the same cycle: rd_data reflects the pre-edge register value (no internal bypass).

Decomposition:
- Shared package holds the HILO_* code localparams (NONE=0..MTLO=8) and the MULT_CYCLES/DIV_CYCLES defaults, so the decoder, hazard unit and this block agree.
- One natural sub-module: hilo_arith, purely combinational. Inputs are a, b and code; outputs are the 64-bit {hi,lo} result and a div_by_zero flag.
- hilo_unit keeps the FSM, counter and registers.

Test Plan:
- Reset, then mult a=0xFFFFFFFE (-2), b=3 -> start=1 for one cycle, busy=1 for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- multu a=0xFFFFFFFF, b=2 -> after 5 busy cycles hi=0x00000001, lo=0xFFFFFFFE.
- div a=0xFFFFFFF9 (-7), b=2 -> busy for 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu a=7, b=0 afterwards -> 10 busy cycles, hi/lo unchanged.
- mthi a=0x12345678, then mflo after mtlo a=0xCAFEBABE -> hi=0x12345678; rd_data=0xCAFEBABE in the mflo cycle.
- During a mult busy period, drive mthi a=0xDEAD and a second mult -> both ignored, start=0; the final hi/lo equal the first mult's result.
- Reset asserted in the 3rd busy cycle of a div -> next cycle busy=0, hi=lo=0, and no later commit occurs.
